// File: rtl/abc_seq_master_pkg.sv
// Shared encodings for the soc/eoc sequencing master: FSM state codes and
// handshake level names used on both the upstream and downstream sides.
package abc_seq_master_pkg;

  // FSM state encodings (3-bit, kept as plain constants for legacy tools)
  localparam logic [2:0] S0 = 3'd0;  // idle, eoc high
  localparam logic [2:0] S1 = 3'd1;  // accept request, clear accumulator
  localparam logic [2:0] S2 = 3'd2;  // issue downstream soc
  localparam logic [2:0] S3 = 3'd3;  // wait downstream ack
  localparam logic [2:0] S4 = 3'd4;  // collect downstream result
  localparam logic [2:0] S5 = 3'd5;  // publish sum

  // Handshake levels
  localparam logic EOC_IDLE = 1'b1;
  localparam logic EOC_BUSY = 1'b0;
  localparam logic SOC_ON   = 1'b1;
  localparam logic SOC_OFF  = 1'b0;

endpackage

// File: rtl/abc_acc_step.sv
// One accumulation step: ACC plus the zero-extended 16-bit downstream result.
// Purely combinational; the accumulator register lives in the top module.
module abc_acc_step #(
  parameter int W = 18
) (
  input  logic [W-1:0] i_acc,
  input  logic [15:0]  i_data,
  output logic [W-1:0] o_sum
);

  // Natural (unsigned) addition at full accumulator width
  function automatic logic [W-1:0] add_nat(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    return a + b;
  endfunction

  logic [W-1:0] w_data_ext;

  // Zero-extend the result so it can never be read as negative
  always_comb begin
    w_data_ext = {{(W-16){1'b0}}, i_data};
    o_sum      = add_nat(i_acc, w_data_ext);
  end

endmodule

// File: rtl/abc_seq_master.sv
// soc/eoc initiator that runs N back-to-back downstream conversions per
// upstream request and returns their sum. The upstream side behaves as a
// soc/eoc responder, so this block chains like any other conversion unit.
//
// state | meaning
// S0    | idle, eoc=1, waiting for upstream soc
// S1    | request accepted, eoc=0, ACC/CNT cleared, waiting for soc to drop
// S2    | wait for downstream idle (eoc_d=1), then raise soc_d
// S3    | wait for downstream ack (eoc_d=0), then drop soc_d
// S4    | wait for downstream result (eoc_d=1), accumulate, count
// S5    | publish sum on out, raise eoc
module abc_seq_master
  import abc_seq_master_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 16 + $clog2(N)
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  output logic         eoc,
  output logic [W-1:0] out,
  output logic         soc_d,
  input  logic         eoc_d,
  input  logic [15:0]  data_d
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_out;
  logic          r_eoc;
  logic          r_soc_d;
  logic [W-1:0]  w_acc_next;

  abc_acc_step #(.W(W)) u_acc_step (
    .i_acc  (r_acc),
    .i_data (data_d),
    .o_sum  (w_acc_next)
  );

  // Sequencer: every output is a register; reset forces soc_d low at once
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= S0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_eoc   <= EOC_IDLE;
      r_soc_d <= SOC_OFF;
    end else begin
      case (r_state)
        S0: begin
          r_eoc <= EOC_IDLE;
          if (soc) r_state <= S1;
        end
        S1: begin
          r_eoc <= EOC_BUSY;
          r_acc <= '0;
          r_cnt <= '0;
          if (!soc) r_state <= S2;
        end
        S2: begin
          if (eoc_d == EOC_IDLE) begin
            r_soc_d <= SOC_ON;
            r_state <= S3;
          end
        end
        S3: begin
          if (eoc_d == EOC_BUSY) begin
            r_soc_d <= SOC_OFF;
            r_state <= S4;
          end
        end
        S4: begin
          if (eoc_d == EOC_IDLE) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            r_state <= (r_cnt == CNT_LAST) ? S5 : S2;
          end
        end
        S5: begin
          r_out   <= r_acc;
          r_eoc   <= EOC_IDLE;
          r_state <= S0;
        end
        default: begin
          r_soc_d <= SOC_OFF;
          r_eoc   <= EOC_IDLE;
          r_state <= S0;
        end
      endcase
    end
  end

  assign eoc   = r_eoc;
  assign out   = r_out;
  assign soc_d = r_soc_d;

endmodule

// File: tb/tb_abc_seq_master.sv
// Bench for abc_seq_master: a behavioural downstream responder serves queued
// results with queued delays; expected sums are computed from those queues.
module tb_abc_seq_master;

  localparam int N = 4;
  localparam int W = 18;

  logic          clock = 1'b0;
  logic          reset_;
  logic          soc;
  logic          eoc;
  logic [W-1:0]  out;
  logic          soc_d;
  logic          eoc_d;
  logic [15:0]   data_d;

  int            n_cmp = 0;
  int            n_bad = 0;

  logic [15:0]   vq[$];
  int            dq[$];
  int            hold_cnt = 0;
  int            soc_d_rises = 0;
  int            early_issue = 0;
  logic          soc_d_prev = 1'b0;
  logic          eoc_d_at_pos = 1'b1;
  logic [W-1:0]  model_out = '0;

  always #5 clock = ~clock;

  abc_seq_master #(.N(N), .W(W)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .soc    (soc),
    .eoc    (eoc),
    .out    (out),
    .soc_d  (soc_d),
    .eoc_d  (eoc_d),
    .data_d (data_d)
  );

  // Downstream responder model
  initial begin
    int d;
    int g;
    eoc_d  = 1'b1;
    data_d = 16'h0000;
    forever begin
      @(negedge clock);
      if (hold_cnt > 0) begin
        eoc_d = 1'b0;
        hold_cnt--;
        if (hold_cnt == 0) eoc_d = 1'b1;
      end else if (soc_d === 1'b1 && eoc_d === 1'b1) begin
        eoc_d = 1'b0;
        d = (dq.size() > 0) ? dq.pop_front() : 0;
        data_d = (vq.size() > 0) ? vq.pop_front() : 16'(($urandom));
        g = 0;
        while (soc_d === 1'b1 && g < 500) begin
          @(negedge clock);
          g++;
        end
        repeat (d) @(negedge clock);
        eoc_d = 1'b1;
      end
    end
  end

  // Protocol monitor: soc_d rises, and rises issued while downstream busy
  always @(posedge clock) eoc_d_at_pos = eoc_d;
  always @(negedge clock) begin
    if (soc_d === 1'b1 && soc_d_prev === 1'b0) begin
      soc_d_rises++;
      if (eoc_d_at_pos !== 1'b1) early_issue++;
    end
    soc_d_prev = soc_d;
  end

  task automatic request(input logic [15:0] vals[N], input int dels[N],
                         input int soc_hold, input bit poke, input string name,
                         output int lat);
    logic [W-1:0] exp;
    bit steady;
    bit hold_ok;
    int g;
    exp = '0;
    for (int i = 0; i < N; i++) begin
      vq.push_back(vals[i]);
      dq.push_back(dels[i]);
      exp += W'(vals[i]);
    end
    steady = 1'b1;
    hold_ok = 1'b1;
    soc_d_rises = 0;
    @(negedge clock);
    soc = 1'b1;
    for (int i = 0; i < soc_hold; i++) begin
      @(negedge clock);
      if (i >= 2 && eoc !== 1'b0) hold_ok = 1'b0;
      if (soc_d !== 1'b0) hold_ok = 1'b0;
      if (out !== model_out) steady = 1'b0;
    end
    g = 0;
    while (eoc !== 1'b0 && g < 50) begin
      @(negedge clock);
      g++;
    end
    n_cmp++;
    if (eoc !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: eoc=%b required 0", name, eoc);
    end
    n_cmp++;
    if (!hold_ok) begin
      n_bad++;
      $display("FAIL %s soc_hold: activity seen while soc held, required none", name);
    end
    soc = 1'b0;
    lat = 0;
    while (eoc !== 1'b1 && lat < 3000) begin
      @(negedge clock);
      lat++;
      if (poke && lat == 4) soc = 1'b1;
      if (poke && lat == 6) soc = 1'b0;
      if (eoc !== 1'b1 && out !== model_out) steady = 1'b0;
    end
    soc = 1'b0;
    n_cmp++;
    if (eoc !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done: eoc=%b required 1 (timeout)", name, eoc);
    end
    n_cmp++;
    if (out !== exp) begin
      n_bad++;
      $display("FAIL %s sum: out=%h required %h", name, out, exp);
    end
    n_cmp++;
    if (soc_d_rises != N) begin
      n_bad++;
      $display("FAIL %s issues: soc_d rises=%0d required %0d", name, soc_d_rises, N);
    end
    n_cmp++;
    if (!steady) begin
      n_bad++;
      $display("FAIL %s hold_out: out changed before publish, required %h", name, model_out);
    end
    model_out = exp;
    if (poke) begin
      repeat (4) @(negedge clock);
      n_cmp++;
      if (eoc !== 1'b1 || soc_d_rises != N) begin
        n_bad++;
        $display("FAIL %s busy_soc: eoc=%b rises=%0d required 1/%0d", name, eoc, soc_d_rises, N);
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] v[N];
    int dl[N];
    int lat;
    int g;
    reset_ = 1'b0;
    soc = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (eoc !== 1'b1 || soc_d !== 1'b0 || out !== '0) begin
      n_bad++;
      $display("FAIL reset_init: eoc=%b soc_d=%b out=%h required 1/0/0", eoc, soc_d, out);
    end
    reset_ = 1'b1;
    v = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    dl = '{3, 3, 3, 3};
    request(v, dl, 3, 1'b0, "pre_reset", lat);
    // start a run and abort it while soc_d is high (S3)
    vq.push_back(16'h5555);
    dq.push_back(4);
    @(negedge clock);
    soc = 1'b1;
    repeat (3) @(negedge clock);
    soc = 1'b0;
    g = 0;
    do begin
      @(posedge clock);
      #1;
      g++;
    end while (soc_d !== 1'b1 && g < 100);
    reset_ = 1'b0;
    #1;
    n_cmp++;
    if (eoc !== 1'b1 || soc_d !== 1'b0 || out !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_s3: eoc=%b soc_d=%b out=%h required 1/0/0", eoc, soc_d, out);
    end
    model_out = '0;
    repeat (4) @(negedge clock);
    n_cmp++;
    if (soc_d !== 1'b0 || eoc !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hold: soc_d=%b eoc=%b required 0/1", soc_d, eoc);
    end
    reset_ = 1'b1;
    repeat (10) @(negedge clock);
    vq.delete();
    dq.delete();
    v = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    dl = '{1, 0, 2, 0};
    request(v, dl, 3, 1'b0, "restart", lat);
  endtask

  task automatic test_same_value();
    logic [15:0] v[N];
    int dl[N];
    int lat;
    v = '{16'h1234, 16'h1234, 16'h1234, 16'h1234};
    dl = '{0, 0, 0, 0};
    request(v, dl, 3, 1'b0, "x1234", lat);
    n_cmp++;
    if (out !== 18'h048D0) begin
      n_bad++;
      $display("FAIL x1234_const: out=%h required 048d0", out);
    end
    n_cmp++;
    if (lat != 3 * N + 2) begin
      n_bad++;
      $display("FAIL latency: cycles=%0d required %0d", lat, 3 * N + 2);
    end
  endtask

  task automatic test_max();
    logic [15:0] v[N];
    int dl[N];
    int lat;
    v = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    dl = '{2, 0, 1, 0};
    request(v, dl, 3, 1'b0, "xffff", lat);
    n_cmp++;
    if (out !== 18'h3FFFC) begin
      n_bad++;
      $display("FAIL xffff_const: out=%h required 3fffc", out);
    end
  endtask

  task automatic test_delays();
    logic [15:0] v[N];
    int dl[N];
    int lat;
    v = '{16'd1, 16'd2, 16'd3, 16'd4};
    dl = '{0, 5, 1, 9};
    request(v, dl, 3, 1'b0, "delays", lat);
    n_cmp++;
    if (out !== 18'h0000A) begin
      n_bad++;
      $display("FAIL delays_const: out=%h required 0000a", out);
    end
  endtask

  task automatic test_busy_downstream();
    logic [15:0] v[N];
    int dl[N];
    int lat;
    early_issue = 0;
    hold_cnt = 11;
    v = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    dl = '{0, 0, 0, 0};
    request(v, dl, 1, 1'b0, "busy_ds", lat);
    n_cmp++;
    if (early_issue != 0 || lat < 10) begin
      n_bad++;
      $display("FAIL busy_ds_wait: early soc_d=%0d lat=%0d required 0/>=10", early_issue, lat);
    end
  endtask

  task automatic test_soc_long();
    logic [15:0] v[N];
    int dl[N];
    int lat;
    v = '{16'h0ABC, 16'h0001, 16'h7000, 16'h00FF};
    dl = '{1, 1, 1, 1};
    request(v, dl, 20, 1'b0, "soc_long", lat);
  endtask

  task automatic test_back_to_back();
    logic [15:0] v[N];
    int dl[N];
    int lat;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = 16'($urandom);
        dl[i] = int'($urandom_range(0, 7));
      end
      request(v, dl, int'($urandom_range(1, 5)), (k % 2) == 1, $sformatf("rand%0d", k), lat);
    end
    n_cmp++;
    if (early_issue != 0) begin
      n_bad++;
      $display("FAIL protocol: soc_d raised while downstream busy %0d times, required 0", early_issue);
    end
  endtask

  initial begin
    test_reset();
    test_same_value();
    test_max();
    test_delays();
    test_busy_downstream();
    test_soc_long();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
